// File: rtl/btn_cancel_cond.sv
// Cancel push-button conditioner: synchroniser, debouncer, press/long-press events and a fixed-length beep gate.
// Optional BTN_LONG_BEEP_EN: a long press also (re)loads beep_en for 2*BEEP_CYCLES as a confirm beep.
module btn_cancel_cond #(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int BEEP_CYCLES       = 5_000_000,
  parameter int LONG_PRESS_CYCLES = 150_000_000,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_long,
  output logic beep_en
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES) + 1;
`ifdef BTN_LONG_BEEP_EN
  localparam int BEEP_W = $clog2(2 * BEEP_CYCLES) + 1;
`else
  localparam int BEEP_W = $clog2(BEEP_CYCLES) + 1;
`endif

  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [BEEP_W-1:0] BEEP_LOAD  = BEEP_W'(BEEP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

  // Synchroniser: btn_n is 1 while pressed, whatever the board polarity.
  logic btn_n;
  logic sync_q1;
  logic btn_sync;

  assign btn_n = btn_raw ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1  <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sync_q1  <= btn_n;
      btn_sync <= sync_q1;
    end
  end

  // Debouncer: btn_level flips once btn_sync has disagreed for DEBOUNCE_CYCLES cycles.
  logic [DB_W-1:0] db_cnt;
  logic            db_differ;
  logic            db_done;
  logic            rise_evt;
  logic            fall_evt;

  assign db_differ = (btn_sync != btn_level);
  assign db_done   = db_differ && (db_cnt == DB_LAST);
  assign rise_evt  = db_done && !btn_level;
  assign fall_evt  = db_done && btn_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
      btn_press <= 1'b0;
    end else begin
      btn_press <= rise_evt;
      if (!db_differ) begin
        db_cnt <= '0;
      end else if (db_done) begin
        db_cnt    <= '0;
        btn_level <= ~btn_level;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Hold tracker. HELD is entered on the same edge btn_level rises, so the
  // registered btn_long lands LONG_PRESS_CYCLES cycles after that rise.
  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic              long_fire;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    long_fire = 1'b0;
    case (state)
      IDLE: begin
        if (rise_evt) begin
          state_nxt = HELD;
          hold_nxt  = '0;
        end
      end
      HELD: begin
        // A release coinciding with the last hold cycle still fires the long press.
        if (hold_cnt == HOLD_LAST) begin
          long_fire = 1'b1;
          state_nxt = LONG;
        end else if (fall_evt) begin
          state_nxt = IDLE;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      LONG: begin
        if (fall_evt) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      btn_long <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      btn_long <= long_fire;
    end
  end

  // Beep gate: loaded on the press edge, counts down to give a fixed-length window.
  logic [BEEP_W-1:0] beep_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      beep_en  <= 1'b0;
      beep_cnt <= '0;
    end else if (rise_evt) begin
      beep_en  <= 1'b1;
      beep_cnt <= BEEP_LOAD;
`ifdef BTN_LONG_BEEP_EN
    end else if (long_fire) begin
      beep_en  <= 1'b1;
      beep_cnt <= BEEP_W'(2 * BEEP_CYCLES - 1);
`endif
    end else if (beep_en) begin
      if (beep_cnt == '0) begin
        beep_en <= 1'b0;
      end else begin
        beep_cnt <= beep_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_btn_cancel_cond.sv
// Bench for btn_cancel_cond: directed steps plus random button traffic, every cycle checked
// against a run-length/timestamp model of the button rules.
module tb_btn_cancel_cond;

  localparam int DEB  = 4;
  localparam int BEEP = 10;
  localparam int LNG  = 50;
  localparam bit AL   = 1'b1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_raw = 1'b1;
  logic btn_level;
  logic btn_press;
  logic btn_long;
  logic beep_en;

  always #5 clk = ~clk;

  btn_cancel_cond #(
    .DEBOUNCE_CYCLES  (DEB),
    .BEEP_CYCLES      (BEEP),
    .LONG_PRESS_CYCLES(LNG),
    .ACTIVE_LOW       (AL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_long (btn_long),
    .beep_en  (beep_en)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int press_cnt = 0;
  int long_cnt  = 0;
  int press_cyc = -1;
  int long_cyc  = -1;

  // Model: two-stage input pipe, disagreement run length, count of consecutive
  // high-level cycles, and the cycle at which the beep window ends.
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  logic m_lvl = 1'b0;
  logic m_press = 1'b0;
  logic m_long = 1'b0;
  logic m_beep = 1'b0;
  int   m_run = 0;
  int   m_hi = 0;
  int   m_beep_end = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick(input logic r, input logic raw);
    reset   = r;
    btn_raw = raw;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0;
      m_press = 1'b0; m_long = 1'b0;
      m_run = 0; m_hi = 0; m_beep_end = 0;
    end else begin
      m_long  = (m_hi == LNG);
      m_press = 1'b0;
      if (m_s2 != m_lvl) m_run++;
      else m_run = 0;
      if (m_run == DEB) begin
        m_lvl   = !m_lvl;
        m_run   = 0;
        m_press = m_lvl;
      end
      m_s2 = m_s1;
      m_s1 = raw ^ AL;
      m_hi = m_lvl ? m_hi + 1 : 0;
      if (m_press) m_beep_end = cyc + BEEP;
`ifdef BTN_LONG_BEEP_EN
      if (m_long) m_beep_end = cyc + 2 * BEEP;
`endif
    end
    m_beep = (cyc < m_beep_end);
    #1;
    check("btn_level", btn_level, m_lvl);
    check("btn_press", btn_press, m_press);
    check("btn_long", btn_long, m_long);
    check("beep_en", beep_en, m_beep);
    if (btn_press === 1'b1) begin press_cnt++; press_cyc = cyc; end
    if (btn_long === 1'b1) begin long_cnt++; long_cyc = cyc; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int p0;
    int l0;
    int n;
    logic lvl;

    // Reset, then idle with the button released.
    repeat (3) tick(1'b1, 1'b1);
    repeat (100) tick(1'b0, 1'b1);
    check_int("idle_press_count", press_cnt, 0);

    // Single clean press: btn_press DEB+2 edges after the raw edge.
    t0 = cyc;
    p0 = press_cnt;
    repeat (30) tick(1'b0, 1'b0);
    check_int("press_latency", press_cyc - t0, DEB + 2);
    check_int("single_press_count", press_cnt - p0, 1);
    repeat (20) tick(1'b0, 1'b1);

    // Short glitches never reach btn_level.
    p0 = press_cnt;
    repeat (5) begin
      repeat (3) tick(1'b0, 1'b0);
      repeat (2) tick(1'b0, 1'b1);
    end
    repeat (10) tick(1'b0, 1'b1);
    check_int("glitch_press_count", press_cnt - p0, 0);

    // Long hold: exactly one btn_long, LNG cycles after btn_level rises.
    l0 = long_cnt;
    repeat (80) tick(1'b0, 1'b0);
    check_int("long_count", long_cnt - l0, 1);
    check_int("long_latency", long_cyc - press_cyc, LNG);
    repeat (30) tick(1'b0, 1'b1);

    // Back-to-back presses retrigger the beep (closest spacing debounce allows).
    repeat (4) tick(1'b0, 1'b0);
    repeat (4) tick(1'b0, 1'b1);
    repeat (20) tick(1'b0, 1'b0);
    repeat (20) tick(1'b0, 1'b1);

    // Reset mid-beep, then re-debounce with the button still held.
    repeat (DEB + 2 + 3) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check("reset_beep", beep_en, 1'b0);
    t0 = cyc;
    repeat (10) tick(1'b0, 1'b0);
    check_int("redebounce_latency", press_cyc - t0, DEB + 2);
    // Reset 30 cycles into the hold: no long press ever follows.
    l0 = long_cnt;
    repeat (26) tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    check("reset_level", btn_level, 1'b0);
    repeat (60) tick(1'b0, 1'b1);
    check_int("aborted_long_count", long_cnt - l0, 0);

    // Random button traffic with occasional resets.
    repeat (70) begin
      n   = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 70) : $urandom_range(1, 8);
      lvl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) tick(1'b1, lvl);
      repeat (n) tick(1'b0, lvl);
    end
    repeat (80) tick(1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
